// File: rtl/boxhead_pkg.sv
// Shared types and constants for the sprite blitter.
package boxhead_pkg;

    localparam int unsigned ADDR_W            = 20;
    localparam int unsigned SCREEN_W          = 640;
    localparam int unsigned SCREEN_H          = 480;
    localparam logic [3:0]  TRANSPARENT_INDEX = 4'd0;

    typedef logic [9:0]         coord_t;
    typedef logic signed [11:0] scoord_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        WRITE,
        DONE
    } blit_state_t;

    // True when a signed destination coordinate lands inside the frame.
    function automatic logic on_screen(input scoord_t dx, input scoord_t dy);
        return !dx[11] && !dy[11] &&
               (dx < scoord_t'(SCREEN_W)) && (dy < scoord_t'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite-memory read path and frame-buffer write path of the blitter.
interface sprite_blitter_if;

    logic [boxhead_pkg::ADDR_W-1:0] src_addr;
    logic [3:0]                     src_index;
    logic [15:0]                    src_color;
    boxhead_pkg::coord_t            program_x;
    boxhead_pkg::coord_t            program_y;
    logic [15:0]                    program_data;
    logic                           program_write;
    logic                           program_ready;

    modport master (
        output src_addr, program_x, program_y, program_data, program_write,
        input  src_index, src_color, program_ready
    );

    modport slave (
        input  src_addr, program_x, program_y, program_data, program_write,
        output src_index, src_color, program_ready
    );

endinterface

// File: rtl/blit_addr_gen.sv
// Walks the sprite raster: column/row counters, source address and destination.
module blit_addr_gen
    import boxhead_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  addr_t             cmd_base,
    input  logic [9:0]        cmd_width,
    input  logic [9:0]        cmd_height,
    input  logic [10:0]       cmd_x,
    input  logic [10:0]       cmd_y,
    input  logic              cmd_flip,
    output addr_t             addr_c,
    output scoord_t           dx_c,
    output scoord_t           dy_c,
    output logic              last_c
);

    logic [9:0]  width_q;
    logic [9:0]  height_q;
    logic [10:0] x_q;
    logic [10:0] y_q;
    logic        flip_q;
    logic [9:0]  col_q;
    logic [9:0]  row_q;
    addr_t       row_base_q;
    logic [9:0]  col_src_c;
    logic        row_end_c;

    // Command latch and raster counters; row_base steps by width, no multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            width_q    <= '0;
            height_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            flip_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else if (load) begin
            width_q    <= cmd_width;
            height_q   <= cmd_height;
            x_q        <= cmd_x;
            y_q        <= cmd_y;
            flip_q     <= cmd_flip;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= cmd_base;
        end else if (advance) begin
            if (row_end_c) begin
                col_q      <= '0;
                row_q      <= row_q + 10'd1;
                row_base_q <= row_base_q + ADDR_W'(width_q);
            end else begin
                col_q      <= col_q + 10'd1;
            end
        end
    end

    // Source column mirror, address, signed destination and last-pixel flag.
    always_comb begin
        row_end_c = (col_q == width_q - 10'd1);
        col_src_c = flip_q ? (width_q - 10'd1 - col_q) : col_q;
        addr_c    = row_base_q + ADDR_W'(col_src_c);
        dx_c      = scoord_t'({x_q[10], x_q}) + scoord_t'({2'b00, col_q});
        dy_c      = scoord_t'({y_q[10], y_q}) + scoord_t'({2'b00, row_q});
        last_c    = row_end_c && (row_q == height_q - 10'd1);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite copy engine: fetches sprite pixels and writes opaque on-screen ones.
module sprite_blitter
    import boxhead_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  addr_t             cmd_base,
    input  logic [9:0]        cmd_width,
    input  logic [9:0]        cmd_height,
    input  logic [10:0]       cmd_x,
    input  logic [10:0]       cmd_y,
    input  logic              cmd_flip,
    output logic              busy,
    output logic              done,
    sprite_blitter_if.master  bus
);

    blit_state_t state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    addr_t       src_addr_q, src_addr_d;
    scoord_t     dx_q, dx_d;
    scoord_t     dy_q, dy_d;
    coord_t      px_q, px_d;
    coord_t      py_q, py_d;
    logic [15:0] pdata_q, pdata_d;
    logic        pwrite_q, pwrite_d;

    logic        load_c;
    logic        advance_c;
    addr_t       addr_c;
    scoord_t     dx_c;
    scoord_t     dy_c;
    logic        last_c;
    logic        skip_c;

    blit_addr_gen u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .advance    (advance_c),
        .cmd_base   (cmd_base),
        .cmd_width  (cmd_width),
        .cmd_height (cmd_height),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_flip   (cmd_flip),
        .addr_c     (addr_c),
        .dx_c       (dx_c),
        .dy_c       (dy_c),
        .last_c     (last_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_addr_q <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pdata_q    <= '0;
            pwrite_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            src_addr_q <= src_addr_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            px_q       <= px_d;
            py_q       <= py_d;
            pdata_q    <= pdata_d;
            pwrite_q   <= pwrite_d;
        end
    end

    // Next state, next output values and counter strobes.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        src_addr_d = src_addr_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        px_d       = px_q;
        py_d       = py_q;
        pdata_d    = pdata_q;
        pwrite_d   = pwrite_q;
        load_c     = 1'b0;
        advance_c  = 1'b0;
        skip_c     = (bus.src_index == TRANSPARENT_INDEX) || !on_screen(dx_q, dy_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c = 1'b1;
                    if ((cmd_width == 10'd0) || (cmd_height == 10'd0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        busy_d  = 1'b1;
                    end
                end
            end
            FETCH: begin
                src_addr_d = addr_c;
                dx_d       = dx_c;
                dy_d       = dy_c;
                state_d    = EVAL;
            end
            EVAL: begin
                if (skip_c) begin
                    advance_c = 1'b1;
                    if (last_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    px_d     = dx_q[9:0];
                    py_d     = dy_q[9:0];
                    pdata_d  = bus.src_color;
                    pwrite_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (bus.program_ready) begin
                    pwrite_d  = 1'b0;
                    advance_c = 1'b1;
                    if (last_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.src_addr      = src_addr_q;
    assign bus.program_x     = px_q;
    assign bus.program_y     = py_q;
    assign bus.program_data  = pdata_q;
    assign bus.program_write = pwrite_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed commands, decoupled monitor.
module tb_sprite_blitter;
    import boxhead_pkg::*;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    addr_t       cmd_base;
    logic [9:0]  cmd_width;
    logic [9:0]  cmd_height;
    logic [10:0] cmd_x;
    logic [10:0] cmd_y;
    logic        cmd_flip;
    logic        busy;
    logic        done;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cmd_base   (cmd_base),
        .cmd_width  (cmd_width),
        .cmd_height (cmd_height),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_flip   (cmd_flip),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    // Sprite memory: palette index table, colour encodes the address it came from.
    logic [3:0] mem_idx [0:1023];
    assign bus.src_index = mem_idx[bus.src_addr[9:0]];
    assign bus.src_color = {6'h30, bus.src_addr[9:0]};

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    n_wr = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    last_wr_cyc = -1;
    int    first_wr_cyc = -1;
    int    first_run = -1;
    int    run = 0;
    int    start_cyc = 0;
    bit    addr_chk = 1'b1;
    addr_t prev_addr = '0;
    wr_t   wr_q[$];
    addr_t addr_q[$];
    wr_t   got;
    wr_t   exp_wr;
    addr_t exp_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected writes/addresses as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.program_write) run++;
                if (bus.program_write && bus.program_ready) begin
                    n_wr++;
                    last_wr_cyc = cyc;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    if (first_run < 0) first_run = run;
                    run = 0;
                    got = {bus.program_x, bus.program_y, bus.program_data};
                    if (wr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL wr_unexpected: got x=%0d y=%0d d=0x%0h, expected no write",
                                 got.x, got.y, got.d);
                    end else begin
                        exp_wr = wr_q.pop_front();
                        chk("wr_xyd", 64'(got), 64'(exp_wr));
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_with_done", 64'(busy), 64'd0);
                end
                if (addr_chk && (bus.src_addr != prev_addr)) begin
                    if (addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL addr_unexpected: got 0x%0h, expected no fetch", bus.src_addr);
                    end else begin
                        exp_addr = addr_q.pop_front();
                        chk("src_addr", 64'(bus.src_addr), 64'(exp_addr));
                    end
                end
            end
            prev_addr = bus.src_addr;
        end
    end

    task automatic push_wr(input int x, input int y, input int a);
        wr_t e;
        e.x = 10'(x);
        e.y = 10'(y);
        e.d = {6'h30, 10'(a)};
        wr_q.push_back(e);
    endtask

    task automatic do_cmd(input int base, input int w, input int h,
                          input int x, input int y, input bit flip);
        @(negedge clk);
        cmd_base   = ADDR_W'(base);
        cmd_width  = 10'(w);
        cmd_height = 10'(h);
        cmd_x      = 11'(x);
        cmd_y      = 11'(y);
        cmd_flip   = flip;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(done_cnt > d0), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_write"}, 64'(bus.program_write), 64'd0);
        chk({tag, "_x"},     64'(bus.program_x), 64'd0);
        chk({tag, "_y"},     64'(bus.program_y), 64'd0);
        chk({tag, "_data"},  64'(bus.program_data), 64'd0);
        chk({tag, "_addr"},  64'(bus.src_addr), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        int k;
        for (int i = 0; i < 1024; i++) mem_idx[i] = 4'd5;
        reset = 1'b1;
        start = 1'b0;
        cmd_base = '0; cmd_width = '0; cmd_height = '0;
        cmd_x = '0; cmd_y = '0; cmd_flip = 1'b0;
        bus.program_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");

        // 2x2 opaque sprite at (10,20)
        d0 = done_cnt; w0 = n_wr; first_wr_cyc = -1;
        for (int a = 'h100; a < 'h104; a++) addr_q.push_back(ADDR_W'(a));
        push_wr(10, 20, 'h100); push_wr(11, 20, 'h101);
        push_wr(10, 21, 'h102); push_wr(11, 21, 'h103);
        do_cmd('h100, 2, 2, 10, 20, 1'b0);
        wait_done("t1_done", d0);
        chk("t1_first_write_latency", 64'(first_wr_cyc - start_cyc), 64'd2);
        chk("t1_done_after_write", 64'(done_cyc - last_wr_cyc), 64'd1);
        chk("t1_write_count", 64'(n_wr - w0), 64'd4);

        // Transparent pixel at (1,0)
        mem_idx['h101] = 4'd0;
        d0 = done_cnt; w0 = n_wr;
        for (int a = 'h100; a < 'h104; a++) addr_q.push_back(ADDR_W'(a));
        push_wr(10, 20, 'h100); push_wr(10, 21, 'h102); push_wr(11, 21, 'h103);
        do_cmd('h100, 2, 2, 10, 20, 1'b0);
        wait_done("t2_done", d0);
        chk("t2_write_count", 64'(n_wr - w0), 64'd3);
        mem_idx['h101] = 4'd5;

        // Clipping at left and bottom edges
        d0 = done_cnt; w0 = n_wr;
        for (int a = 'h200; a < 'h206; a++) addr_q.push_back(ADDR_W'(a));
        push_wr(0, 479, 'h201); push_wr(1, 479, 'h202);
        do_cmd('h200, 3, 2, -1, 479, 1'b0);
        wait_done("t3_done", d0);
        chk("t3_write_count", 64'(n_wr - w0), 64'd2);

        // Back-pressure: ready low for 5 cycles on first write
        d0 = done_cnt; w0 = n_wr; first_run = -1;
        addr_q.push_back(ADDR_W'('h300)); addr_q.push_back(ADDR_W'('h301));
        push_wr(100, 200, 'h300); push_wr(101, 200, 'h301);
        bus.program_ready = 1'b0;
        do_cmd('h300, 2, 1, 100, 200, 1'b0);
        k = 0;
        while (!bus.program_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_stall_write", 64'(bus.program_write), 64'd1);
            chk("t4_stall_xyd", 64'({bus.program_x, bus.program_y, bus.program_data}),
                64'({10'd100, 10'd200, 16'hC300}));
        end
        @(posedge clk);
        #1 bus.program_ready = 1'b1;
        wait_done("t4_done", d0);
        chk("t4_write_high_cycles", 64'(first_run), 64'd6);
        chk("t4_write_count", 64'(n_wr - w0), 64'd2);

        // Horizontal flip
        d0 = done_cnt; w0 = n_wr;
        addr_q.push_back(ADDR_W'(2)); addr_q.push_back(ADDR_W'(1)); addr_q.push_back(ADDR_W'(0));
        push_wr(0, 0, 2); push_wr(1, 0, 1); push_wr(2, 0, 0);
        do_cmd(0, 3, 1, 0, 0, 1'b1);
        wait_done("t5_done", d0);
        chk("t5_write_count", 64'(n_wr - w0), 64'd3);

        // Zero width: immediate done, no writes
        d0 = done_cnt; w0 = n_wr;
        do_cmd('h50, 0, 5, 3, 3, 1'b0);
        wait_done("t6_done", d0);
        chk("t6_done_latency", 64'(done_cyc - start_cyc), 64'd0);
        repeat (5) @(negedge clk);
        chk("t6_write_count", 64'(n_wr - w0), 64'd0);
        chk("t6_single_done", 64'(done_cnt - d0), 64'd1);

        // Start while busy is ignored
        d0 = done_cnt; w0 = n_wr;
        addr_q.push_back(ADDR_W'('h380)); addr_q.push_back(ADDR_W'('h381));
        push_wr(5, 5, 'h380); push_wr(6, 5, 'h381);
        do_cmd('h380, 2, 1, 5, 5, 1'b0);
        @(negedge clk);
        cmd_width = 10'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t7_done", d0);
        repeat (5) @(negedge clk);
        chk("t7_single_done", 64'(done_cnt - d0), 64'd1);
        chk("t7_write_count", 64'(n_wr - w0), 64'd2);
        chk("t7_done_after_write", 64'(done_cyc - last_wr_cyc), 64'd1);

        // Reset mid-blit while a write is stalled
        addr_chk = 1'b0;
        d0 = done_cnt; w0 = n_wr;
        bus.program_ready = 1'b0;
        do_cmd('h100, 2, 2, 10, 20, 1'b0);
        k = 0;
        while (!bus.program_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t8_write_pending", 64'(bus.program_write), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t8_after_reset");
        repeat (10) @(negedge clk);
        chk("t8_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t8_no_write", 64'(n_wr - w0), 64'd0);
        chk("t8_busy_low", 64'(busy), 64'd0);
        bus.program_ready = 1'b1;

        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("addr_queue_drained", 64'(addr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
